hazard_ctrl: RTL and testbench

Parametrised load-use and branch-operand hazard controller for the 5-stage MIPS pipeline, sitting beside the ID stage and driving the PC, IF/ID and ID/EX control.
- Generalises the single-cycle load-use stall to configurable load latency, branches resolved in ID, and multi-cycle data-memory waits.
- Suppresses false hazards on `$zero` and on unused source fields.
- Tracks multi-cycle stalls with a small FSM.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_match.sv | 16 +
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
package hazard_pkg;

    // Two-state stall tracker: IDLE watches for hits, STALL counts out extra bubbles
    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    // Holds LOAD_LAT+1-1 = up to 7 remaining bubbles
    localparam int REMAIN_W = 3;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic id_flush;
        logic ex_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = 4'b1100;
    localparam ctrl_t CTRL_BUBBLE = 4'b0010;
    localparam ctrl_t CTRL_HOLD   = 4'b0001;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - source/destination register match with $zero and use-bit qualification
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  logic [REG_AW-1:0] dst,
    output logic              hit
);

    // $zero never carries a real dependency, and unread fields must not stall
    assign hit = use_src && (src != '0) && (src == dst);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch-operand hazard controller; HAZARD_STATS_EN adds stall counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] IFID_regRs,
    input  logic [REG_AW-1:0] IFID_regRt,
    input  logic              IFID_useRs,
    input  logic              IFID_useRt,
    input  logic              IFID_branch,
    input  logic              IDEX_memRead,
    input  logic              IDEX_regWrite,
    input  logic [REG_AW-1:0] IDEX_regRd,
    input  logic              EXMEM_memRead,
    input  logic              EXMEM_memWrite,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              IFID_write,
    output logic              ID_flush,
    output logic              EX_hold
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    localparam logic [REMAIN_W:0] LAT_N = LOAD_LAT[REMAIN_W:0];

    hz_state_t           state_q, state_d;
    logic [REMAIN_W-1:0] remain_q, remain_d;
    logic                rs_hit, rt_hit, any_match;
    logic                lu_hit, br_hit, mem_wait;
    logic [REMAIN_W:0]   stall_len;
    ctrl_t               ctrl;

    hazard_match #(.REG_AW(REG_AW)) u_match_rs (
        .src     (IFID_regRs),
        .use_src (IFID_useRs),
        .dst     (IDEX_regRd),
        .hit     (rs_hit)
    );

    hazard_match #(.REG_AW(REG_AW)) u_match_rt (
        .src     (IFID_regRt),
        .use_src (IFID_useRt),
        .dst     (IDEX_regRd),
        .hit     (rt_hit)
    );

    assign any_match = rs_hit | rt_hit;
    assign lu_hit    = IDEX_memRead & any_match;
    assign br_hit    = IFID_branch & IDEX_regWrite & ~IDEX_memRead & any_match;
    assign mem_wait  = (EXMEM_memRead | EXMEM_memWrite) & ~mem_ready;

    // Required bubble count: a branch needs one more than a plain load-use, ALU->branch needs one
    always_comb begin
        stall_len = 1;
        if (lu_hit) begin
            stall_len = IFID_branch ? LAT_N + 1'b1 : LAT_N;
        end
    end

    // Next-state and control: memory wait freezes everything, STALL ignores hits
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        ctrl     = CTRL_RUN;
        if (rst) begin
            ctrl = CTRL_RUN;
        end else if (mem_wait) begin
            ctrl = CTRL_HOLD;
        end else if (state_q == STALL) begin
            ctrl     = CTRL_BUBBLE;
            remain_d = remain_q - 1'b1;
            if (remain_q == 1) begin
                state_d = IDLE;
            end
        end else if (lu_hit || br_hit) begin
            ctrl = CTRL_BUBBLE;
            if (stall_len > 1) begin
                state_d  = STALL;
                remain_d = REMAIN_W'(stall_len - 1'b1);
            end
        end
    end

    // FSM register with synchronous reset abandoning any stall in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    assign PCWrite    = ctrl.pc_write;
    assign IFID_write = ctrl.ifid_write;
    assign ID_flush   = ctrl.id_flush;
    assign EX_hold    = ctrl.ex_hold;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Counters wrap naturally at 2^CNT_W
    always_comb begin
        stall_cycles_d = stall_cycles_q + (ctrl.pc_write ? CNT_W'(0) : CNT_W'(1));
        bubble_cnt_d   = bubble_cnt_q + (ctrl.id_flush ? CNT_W'(1) : CNT_W'(0));
    end

    // Statistics registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign bubble_cnt   = bubble_cnt_q;
`else
    // CNT_W only sizes the stats counters; referenced here so the default build still elaborates it
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl at LOAD_LAT 1, 2 and 3
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       branch;
        logic       idex_mr;
        logic       idex_rw;
        logic [4:0] rd;
        logic       exmem_mr;
        logic       exmem_mw;
        logic       mem_ready;
    } vec_t;

    typedef struct {
        int         inst;
        logic [3:0] exp;
        string      name;
    } sb_t;

    localparam logic [3:0] RUN  = 4'b1100;
    localparam logic [3:0] BUB  = 4'b0010;
    localparam logic [3:0] HOLD = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vin [3];
    logic pcw [3];
    logic ifw [3];
    logic fl  [3];
    logic eh  [3];
`ifdef HAZARD_STATS_EN
    logic [31:0] st_cyc [3];
    logic [31:0] bub_c  [3];
`endif

    sb_t sbq [$];
    int  checks = 0;
    int  errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_ctrl #(.REG_AW(5), .LOAD_LAT(g + 1), .CNT_W(32)) u_dut (
            .clk            (clk),
            .rst            (vin[g].rst),
            .IFID_regRs     (vin[g].rs),
            .IFID_regRt     (vin[g].rt),
            .IFID_useRs     (vin[g].use_rs),
            .IFID_useRt     (vin[g].use_rt),
            .IFID_branch    (vin[g].branch),
            .IDEX_memRead   (vin[g].idex_mr),
            .IDEX_regWrite  (vin[g].idex_rw),
            .IDEX_regRd     (vin[g].rd),
            .EXMEM_memRead  (vin[g].exmem_mr),
            .EXMEM_memWrite (vin[g].exmem_mw),
            .mem_ready      (vin[g].mem_ready),
            .PCWrite        (pcw[g]),
            .IFID_write     (ifw[g]),
            .ID_flush       (fl[g]),
            .EX_hold        (eh[g])
`ifdef HAZARD_STATS_EN
            ,
            .stall_cycles   (st_cyc[g]),
            .bubble_cnt     (bub_c[g])
`endif
        );
    end

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic br,
                                input logic mr, input logic rw, input logic [4:0] rd,
                                input logic emr, input logic rdy, input logic r);
        vec_t v;
        v.rst       = r;
        v.rs        = rs;
        v.rt        = rt;
        v.use_rs    = urs;
        v.use_rt    = urt;
        v.branch    = br;
        v.idex_mr   = mr;
        v.idex_rw   = rw;
        v.rd        = rd;
        v.exmem_mr  = emr;
        v.exmem_mw  = 1'b0;
        v.mem_ready = rdy;
        return v;
    endfunction

    vec_t idle_v;

    // Drive one cycle: instance k gets x, the others idle; queue expectations for all three
    task automatic step(input int k, input vec_t x, input logic [3:0] e, input string nm);
        for (int i = 0; i < 3; i++) begin
            sb_t s;
            vin[i] = (i == k) ? x : idle_v;
            s.inst = i;
            s.exp  = (i == k) ? e : RUN;
            s.name = (i == k) ? nm : "idle_run";
            sbq.push_back(s);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                sb_t s;
                logic [3:0] act;
                s   = sbq.pop_front();
                act = {pcw[s.inst], ifw[s.inst], fl[s.inst], eh[s.inst]};
                checks++;
                if (act !== s.exp) begin
                    errors++;
                    $display("FAIL %s inst%0d: got %b expected %b", s.name, s.inst, act, s.exp);
                end
            end
        end
    end

    initial begin
        vec_t rst_v, bub_v;
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst_v  = mk(2, 1, 1, 1, 0, 1, 1, 2, 0, 1, 1);
        bub_v  = mk(2, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) vin[i] = rst_v;
        #1;

        // Reset state: hit inputs present but rst forces run
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 3; i++) begin
                sb_t s;
                s.inst = i; s.exp = RUN; s.name = "reset_run";
                sbq.push_back(s);
            end
            @(posedge clk);
            #1;
        end

        // LOAD_LAT=1: lw $2 then add $3,$2,$1
        step(0, mk(2, 1, 1, 1, 0, 1, 1, 2, 0, 1, 0), BUB, "lat1_lu_bubble");
        step(0, bub_v, RUN, "lat1_lu_run");
        // $zero and unused rt never stall
        step(0, mk(0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0), RUN, "zero_reg");
        step(0, mk(1, 5, 1, 0, 0, 1, 1, 5, 0, 1, 0), RUN, "unused_rt");
        // Branch with ALU result pending: one bubble
        step(0, mk(4, 1, 1, 1, 1, 0, 1, 4, 0, 1, 0), BUB, "br_alu_bubble");
        step(0, mk(4, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0), RUN, "br_alu_run");
        // Branch producer that does not write a register
        step(0, mk(4, 1, 1, 1, 1, 0, 0, 4, 0, 1, 0), RUN, "br_no_regwrite");
        // Branch after lw $4 with LOAD_LAT=1: two bubbles, hit held during STALL
        step(0, mk(4, 1, 1, 1, 1, 1, 1, 4, 0, 1, 0), BUB, "br_lw_bubble1");
        step(0, mk(4, 1, 1, 1, 1, 1, 1, 4, 0, 1, 0), BUB, "br_lw_bubble2");
        step(0, mk(4, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0), RUN, "br_lw_run");

        // LOAD_LAT=2 with two memory-wait cycles after the first bubble
        step(1, mk(2, 1, 1, 1, 0, 1, 1, 2, 0, 1, 0), BUB, "lat2_bubble1");
        step(1, mk(2, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0), HOLD, "lat2_wait1");
        step(1, mk(2, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0), HOLD, "lat2_wait2");
        step(1, mk(2, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0), BUB, "lat2_bubble2");
        step(1, bub_v, RUN, "lat2_run");
        // Load-use coinciding with a memory wait: wait wins, hit re-evaluated after
        step(1, mk(2, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0), HOLD, "lu_vs_wait");
        step(1, mk(2, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0), BUB, "lu_after_wait1");
        step(1, bub_v, BUB, "lu_after_wait2");
        step(1, bub_v, RUN, "lu_after_wait_run");

        // LOAD_LAT=3: three consecutive bubbles
        step(2, mk(2, 1, 1, 1, 0, 1, 1, 2, 0, 1, 0), BUB, "lat3_bubble1");
        step(2, bub_v, BUB, "lat3_bubble2");
        step(2, bub_v, BUB, "lat3_bubble3");
        step(2, bub_v, RUN, "lat3_run");
        // Reset during the 2nd bubble abandons the stall
        step(2, mk(2, 1, 1, 1, 0, 1, 1, 2, 0, 1, 0), BUB, "rst_bubble1");
        step(2, mk(2, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1), RUN, "rst_mid_stall");
`ifdef HAZARD_STATS_EN
        checks++;
        if (st_cyc[2] !== 32'd0 || bub_c[2] !== 32'd0) begin
            errors++;
            $display("FAIL stats_clear: got %0d/%0d expected 0/0", st_cyc[2], bub_c[2]);
        end
`endif
        step(2, bub_v, RUN, "after_rst_idle");

        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
